// File: rtl/dmem_write_arbiter.sv
// dmem_write_arbiter
// Shares the byte-masked dmem write port between the core store path (A) and
// the UART program loader (B). Round-robin arbitration with an optional
// bounded loader burst (b_lock), byte-lane alignment, lane write-enable
// generation and misaligned/illegal store rejection. Memory-side outputs are
// registered (one cycle after accept).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_valid/a_ready               core store handshake (ready is combinational)
//   a_addr/a_wdata/a_size         core byte address, right-justified data, size
//   b_valid/b_ready               loader store handshake (ready is combinational)
//   b_addr/b_wdata/b_size         loader byte address, data, size
//   b_lock                        loader requests burst ownership
//   mem_en/mem_we                 write strobe and 4-bit lane enable
//   mem_addr/mem_din              word address and lane-aligned data
//   err/err_src                   one-cycle reject pulse and its source (0=A, 1=B)
module dmem_write_arbiter #(
  parameter int unsigned AWIDTH    = 14,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [1:0]        a_size,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [1:0]        b_size,
  input  logic              b_lock,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              err,
  output logic              err_src
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, BURST_B = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic [CW-1:0]   burst_cnt;
  logic [CW-1:0]   burst_cnt_nxt;
  logic            burst_cont;
  logic            tie_to_b;
  logic            grant_a;
  logic            grant_b;

  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [1:0]      sel_size;
  logic [1:0]      off;
  logic            legal;
  logic [3:0]      lane_we;
  logic [31:0]     lane_din;
  logic            unused_addr_hi;

  // Loader keeps the port while locked, unless A has waited out a full burst.
  assign burst_cont = (state == BURST_B) && b_valid && b_lock &&
                      ((burst_cnt < CNT_MAX) || !a_valid);

  // Leaving a burst counts B as the last grant, so a waiting A wins the tie.
  assign tie_to_b = (state == BURST_B) ? 1'b0 : !last_grant;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (grant_a || grant_b) begin
        last_grant <= grant_b;
      end
    end
  end

  // Next-state and burst counter
  always_comb begin
    state_nxt     = IDLE;
    burst_cnt_nxt = '0;
    if (grant_b && b_lock) begin
      state_nxt = BURST_B;
      if (burst_cont) begin
        burst_cnt_nxt = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CW'(1);
      end else begin
        burst_cnt_nxt = CW'(1);
      end
    end
  end

  // Grant decode
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (burst_cont) begin
        grant_b = 1'b1;
      end else if (a_valid && b_valid) begin
        grant_b = tie_to_b;
        grant_a = !tie_to_b;
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Request select and lane alignment
  always_comb begin
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
    sel_size  = grant_b ? b_size  : a_size;
    off       = sel_addr[1:0];
    legal     = 1'b0;
    lane_we   = 4'b0000;
    case (sel_size)
      2'b00: begin
        legal   = 1'b1;
        lane_we = 4'b0001 << off;
      end
      2'b01: begin
        legal   = !off[0];
        lane_we = off[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal   = (off == 2'b00);
        lane_we = 4'b1111;
      end
      default: begin
        legal   = 1'b0;
        lane_we = 4'b0000;
      end
    endcase
    lane_din = sel_wdata << {off, 3'b000};
  end

  // Address bits above the memory range are ignored by design.
  assign unused_addr_hi = ^sel_addr[31:AWIDTH+2];

  // Registered memory-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en   <= 1'b0;
      mem_we   <= 4'b0000;
      mem_addr <= '0;
      mem_din  <= '0;
      err      <= 1'b0;
      err_src  <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 4'b0000;
      err    <= 1'b0;
      if (grant_a || grant_b) begin
        err_src <= grant_b;
        if (legal) begin
          mem_en   <= 1'b1;
          mem_we   <= lane_we;
          mem_addr <= sel_addr[AWIDTH+1:2];
          mem_din  <= lane_din;
        end else begin
          err     <= 1'b1;
          mem_din <= '0;
        end
      end
    end
  end

endmodule
